// File: rtl/tag_flush_sched.sv
// Tag flush sequencer: queues tags from the window controller and injects each into the
// column tag allocator, re-flushing while the allocator reports busy, then waits out the kernel.
module tag_flush_sched #(
  parameter int NUM_COL    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RETRY  = 15,
  localparam int TAG_W     = $clog2(NUM_COL) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       kernel_size,
  input  logic             req_valid,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  output logic             flush,
  output logic [TAG_W-1:0] tag_in,
  input  logic             flush_busy,
  output logic             done,
  output logic             abort,
  output logic             cfg_err,
  output logic             tag_err,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       NUM_COL_C = 8'(NUM_COL);
  localparam logic [3:0]       MAX_R_C   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_CHECK = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [TAG_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic             accept, push, pop;
  logic             ks_legal;

  logic [TAG_W-1:0] cur_tag;
  logic [7:0]       ks;
  logic [7:0]       cnt;
  logic [3:0]       retry;
  logic             abort_q, cfg_err_q, tag_err_q;

  // Request handshake: a tag transfers on a rising clk edge where req_valid && req_ready;
  // the requester holds req_valid/req_tag stable until then. req_ready depends only on
  // the registered occupancy, so a pop never raises it within the same cycle.
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && (req_tag != '0);
  assign ks_legal  = (kernel_size != 8'd0) && (kernel_size <= NUM_COL_C);
  assign pop       = (state == S_IDLE) && !empty && ks_legal;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tag_err_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      tag_err_q <= accept && (req_tag == '0);
      if (push) begin
        mem[wr_ptr] <= req_tag;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pop) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_CHECK;
      S_CHECK: begin
        if (!flush_busy)          state_nxt = S_SHIFT;
        else if (retry < MAX_R_C) state_nxt = S_FLUSH;
        else                      state_nxt = S_IDLE;
      end
      S_SHIFT: if (cnt == 8'd0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-tag context; ks is latched at pop so later kernel_size changes do not disturb it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_tag   <= '0;
      ks        <= 8'd0;
      cnt       <= 8'd0;
      retry     <= 4'd0;
      abort_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      abort_q <= (state == S_CHECK) && flush_busy && (retry == MAX_R_C);
      if ((state == S_IDLE) && !empty && !ks_legal) cfg_err_q <= 1'b1;
      if (pop) begin
        cur_tag <= mem[rd_ptr];
        ks      <= kernel_size;
        retry   <= 4'd0;
      end
      if (state == S_CHECK) begin
        if (!flush_busy)           cnt   <= ks - 8'd1;
        else if (retry != MAX_R_C) retry <= retry + 4'd1;
      end
      if ((state == S_SHIFT) && (cnt != 8'd0)) cnt <= cnt - 8'd1;
    end
  end

  always_comb begin
    flush  = 1'b0;
    done   = 1'b0;
    tag_in = '0;
    case (state)
      S_FLUSH: begin
        flush  = 1'b1;
        tag_in = cur_tag;
      end
      S_CHECK, S_SHIFT: tag_in = cur_tag;
      S_DONE: begin
        done   = 1'b1;
        tag_in = cur_tag;
      end
      default: tag_in = '0;
    endcase
  end

  assign abort     = abort_q;
  assign cfg_err   = cfg_err_q;
  assign tag_err   = tag_err_q;
  assign busy      = (state != S_IDLE) || !empty;
  assign state_dbg = state;

endmodule

// File: tb/tb_tag_flush_sched.sv
// Directed bench for tag_flush_sched: reset, single tag, busy retry, abort, queue order,
// illegal kernel_size and reserved tag 0; allocator flush_busy modelled from flush count.
module tb_tag_flush_sched;

  localparam int TAG_W = 4;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd3;

  logic             clk = 1'b0;
  logic             rstn;
  logic [7:0]       kernel_size;
  logic             req_valid;
  logic [TAG_W-1:0] req_tag;
  logic             req_ready;
  logic             flush;
  logic [TAG_W-1:0] tag_in;
  logic             flush_busy = 1'b0;
  logic             done;
  logic             abort;
  logic             cfg_err;
  logic             tag_err;
  logic             busy;
  logic [2:0]       state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_flush = 0;
  int n_done  = 0;
  int n_abort = 0;
  int last_flush_cyc = 0;
  int last_done_cyc  = 0;
  int busy_base  = 0;
  int busy_total = 0;

  logic [TAG_W-1:0] exp_q[$];
  logic [TAG_W-1:0] done_q[$];
  logic [TAG_W-1:0] flush_log[$];

  tag_flush_sched dut (
    .clk         (clk),
    .rstn        (rstn),
    .kernel_size (kernel_size),
    .req_valid   (req_valid),
    .req_tag     (req_tag),
    .req_ready   (req_ready),
    .flush       (flush),
    .tag_in      (tag_in),
    .flush_busy  (flush_busy),
    .done        (done),
    .abort       (abort),
    .cfg_err     (cfg_err),
    .tag_err     (tag_err),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // allocator model and event log: the first busy_total flushes after busy_base see busy
  always @(negedge clk) begin
    if (flush) begin
      flush_log.push_back(tag_in);
      flush_busy = ((n_flush - busy_base) < busy_total);
      n_flush = n_flush + 1;
      last_flush_cyc = cyc;
    end
    if (done) begin
      done_q.push_back(tag_in);
      n_done = n_done + 1;
      last_done_cyc = cyc;
    end
    if (abort) n_abort = n_abort + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [TAG_W-1:0] t);
    int k;
    @(negedge clk);
    req_valid = 1'b1;
    req_tag   = t;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_tag   = '0;
    check("push_accept", 32'(k < 200), 1);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, output bit ok);
    int k = 0;
    while (state_dbg !== s && k < max) begin
      tick();
      k++;
    end
    ok = (state_dbg === s);
  endtask

  task automatic wait_done(input int max, output bit ok);
    int k = 0;
    tick();
    while (done !== 1'b1 && k < max) begin
      tick();
      k++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic sb_compare(input string name);
    check({name, "_cnt"}, done_q.size(), exp_q.size());
    while (done_q.size() > 0 && exp_q.size() > 0)
      check({name, "_tag"}, done_q.pop_front(), exp_q.pop_front());
    done_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit ok;
    int f0, fl0, a0, d0, k;

    rstn = 1'b0;
    kernel_size = 8'd3;
    req_valid = 1'b0;
    req_tag = '0;
    repeat (3) tick();
    check("rst_flush", flush, 0);
    check("rst_done", done, 0);
    check("rst_abort", abort, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_tag_err", tag_err, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_tag_in", tag_in, 0);
    rstn = 1'b1;
    tick();

    // reset mid-SHIFT with a second tag still queued
    push(4'd3);
    push(4'd4);
    wait_state(ST_SHIFT, 50, ok);
    check("mid_reach_shift", ok, 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_flush", flush, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_busy", busy, 0);
    f0 = n_flush;
    tick();
    tick();
    rstn = 1'b1;
    repeat (15) tick();
    check("mid_rst_no_flush", n_flush - f0, 0);
    check("mid_rst_idle", busy, 0);
    check("mid_rst_no_done", done_q.size(), 0);

    // single tag, ks=3, no busy: done 5 cycles after the flush
    kernel_size = 8'd3;
    f0 = n_flush;
    fl0 = flush_log.size();
    exp_q.push_back(4'd3);
    push(4'd3);
    wait_done(50, ok);
    check("single_done_seen", ok, 1);
    check("single_flush_cnt", n_flush - f0, 1);
    check("single_flush_tag", flush_log[fl0], 3);
    check("single_latency", last_done_cyc - last_flush_cyc, 5);
    tick();
    check("single_done_pulse", done, 0);
    sb_compare("single");

    // two busy responses, then clear: three flushes of the same tag
    busy_base = n_flush;
    busy_total = 2;
    f0 = n_flush;
    fl0 = flush_log.size();
    a0 = n_abort;
    exp_q.push_back(4'd3);
    push(4'd3);
    wait_done(100, ok);
    check("retry_done_seen", ok, 1);
    check("retry_flush_cnt", n_flush - f0, 3);
    for (int i = 0; i < 3; i++) check("retry_flush_tag", flush_log[fl0 + i], 3);
    check("retry_latency", last_done_cyc - last_flush_cyc, 5);
    check("retry_no_abort", n_abort - a0, 0);
    sb_compare("retry");

    // busy held: 16 flushes then abort; the queued tag 7 follows
    busy_base = n_flush;
    busy_total = 1000;
    f0 = n_flush;
    fl0 = flush_log.size();
    a0 = n_abort;
    push(4'd6);
    push(4'd7);
    exp_q.push_back(4'd7);
    k = 0;
    while (abort !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    check("abort_seen", abort, 1);
    busy_total = 0;
    check("abort_flush_cnt", n_flush - f0, 16);
    check("abort_first_tag", flush_log[fl0], 6);
    tick();
    check("abort_pulse", abort, 0);
    wait_done(50, ok);
    check("abort_next_done", ok, 1);
    check("abort_next_flush_cnt", n_flush - f0, 17);
    check("abort_next_tag", flush_log[fl0 + 16], 7);
    check("abort_count", n_abort - a0, 1);
    sb_compare("abort");

    // illegal kernel_size stalls the queue; fill it, then release with ks=2
    kernel_size = 8'd0;
    f0 = n_flush;
    d0 = n_done;
    for (int t = 1; t <= 4; t++) begin
      push(4'(t));
      exp_q.push_back(4'(t));
    end
    tick();
    check("cfg0_req_ready", req_ready, 0);
    check("cfg0_err", cfg_err, 1);
    check("cfg0_busy", busy, 1);
    check("cfg0_idle", state_dbg, ST_IDLE);
    check("cfg0_no_flush", n_flush - f0, 0);
    kernel_size = 8'd9;
    repeat (4) tick();
    check("cfg9_err", cfg_err, 1);
    check("cfg9_no_flush", n_flush - f0, 0);
    check("cfg9_retained", req_ready, 0);
    kernel_size = 8'd2;
    exp_q.push_back(4'd5);
    push(4'd5);
    k = 0;
    while ((n_done - d0) < 5 && k < 200) begin
      tick();
      k++;
    end
    check("queue_done_cnt", n_done - d0, 5);
    check("queue_flush_cnt", n_flush - f0, 5);
    check("queue_latency_ks2", last_done_cyc - last_flush_cyc, 4);
    check("queue_cfg_sticky", cfg_err, 1);
    sb_compare("queue");

    // reserved tag 0: accepted, discarded, tag_err for one cycle
    repeat (3) tick();
    f0 = n_flush;
    push(4'd0);
    check("tag0_err_pulse", tag_err, 1);
    @(posedge clk);
    #1;
    check("tag0_err_clear", tag_err, 0);
    repeat (5) tick();
    check("tag0_no_flush", n_flush - f0, 0);
    check("tag0_idle", busy, 0);
    check("tag0_req_ready", req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
